video_mixer_pipe: RTL and testbench
===================================

// Module: video_mixer_pipe
// PURPOSE
//  Parametrised, fully registered successor of the MiST video output mixer. Takes core RGB plus
//  sync/blank and applies blank masking, component-width normalisation and scanline dimming. It then
//  optionally converts to YPbPr (limited or full range) and drives the VGA pins.
//  All colour and sync paths are delayed by the same pipeline, so sync stays pixel-aligned to colour.
// PARAMETERS
//  COLOR_W   6  bits per input colour component, legal range 1..8
//  OUT_W     6  bits per output component, 6 or 8; taken as MSBs of the internal 8-bit value
//  SYNC_POL  1  1 = output sync pulses positive (same as input), 0 = inverted
// PORTS
//  clk_sys     in   1        master clock
//  reset_n     in   1        asynchronous reset, active low
//  ce_pix      in   1        pixel enable; pipeline advances only when high
//  R,G,B       in   COLOR_W  core colour
//  HSync,VSync in   1        positive sync pulses
//  HBlank,VBlank in 1        blanking; colour forced to 0 when either is high
//  scanlines   in   2        0 none, 1 dim to 75%, 2 dim to 50%, 3 dim to 25% on odd lines
//  ypbpr       in   1        1 = YPbPr out (R=Pr, G=Y, B=Pb), 0 = RGB
//  ypbpr_full  in   1        1 = full range 0..255, 0 = limited 16..235/240 (YPbPr only)
//  csync_en    in   1        1 = VGA_HS carries composite sync ~(HS^VS) and VGA_VS is held at 1
//  VGA_R,VGA_G,VGA_B out OUT_W  output colour
//  VGA_HS,VGA_VS out 1       delayed sync, polarity set by SYNC_POL (csync per csync_en)
//  VGA_DE      out  1        delayed ~(HBlank|VBlank)
// BEHAVIOUR
//  - Reset: all pipeline registers = 0; VGA_R/G/B = 0; VGA_DE = 0.
//    VGA_HS/VGA_VS = inactive level (0 if SYNC_POL=1, else 1); line flag = 0.
//  - Latency: exactly 3 ce_pix cycles for colour, sync and DE. With ce_pix low, all registers hold.
//  - S1 (on ce_pix): mask colour with DE. Expand to 8 bits by MSB replication,
//    e.g. 6-bit x -> {x,x[5:4]}, 1-bit x -> {8{x}}.
//    Apply the dim when scanline flag=1 and scanlines!=0:
//      1: (x>>1)+(x>>2)
//      2: x>>1
//      3: x>>2
//  - Line flag: updated in S1 from registered previous HSync/VSync sampled on ce_pix.
//    Toggles on HSync falling edge; cleared on VSync falling edge (clear wins if both in the same cycle).
//  - S2: register 8-bit R,G,B. If ypbpr, compute signed 18-bit products:
//      Y  = 66R+129G+25B
//      Pb = -38R-74G+112B
//      Pr = 112R-94G-18B
//  - S3: add 128, arithmetic shift right 8, then offset: Y+16, Pb/Pr+128.
//    Clamp Y to 16..235 and Pb/Pr to 16..240.
//    If ypbpr_full:
//      Y' = min(255, ((Y-16)*150)>>7)
//      C' = clamp(0..255, 128 + (((C-128)*146)>>>7))
//    Output the MSBs to OUT_W. With ypbpr=0, S3 passes the dimmed RGB through.
//  - Mode inputs (scanlines, ypbpr, ypbpr_full, csync_en) are sampled at the stage that uses them.
//    Mid-frame changes take effect on pixels entering that stage; no glitch beyond that.
//  - Reset mid-line: pipeline flushed to reset values. Outputs resume valid 3 ce_pix after release.
// TESTING
//  1. Reset held, random inputs -> VGA_R/G/B=0, VGA_DE=0, syncs inactive; release -> first valid
//     output exactly 3 ce_pix later.
//  2. ypbpr=0, COLOR_W=6, R=6'h3F, G=6'h20, B=0, DE=1, flag=0 -> VGA_R=63, VGA_G=32, VGA_B=0 (OUT_W=6);
//     same pixel with HBlank=1 -> all 0.
//  3. scanlines=2, white input, two lines -> line 1 output 63, line 2 output 31.
//     VSync falling edge -> flag=0 on next line; simultaneous HS+VS fall -> flag 0.
//  4. ypbpr=1, limited: white -> Y=235, Pb=128, Pr=128 (8-bit, OUT_W=8); black -> Y=16, Pb=Pr=128.
//  5. ypbpr_full=1: white -> Y=255; black -> Y=0; pure blue -> Pb=255.
//  6. ce_pix every 4th clk_sys with random pixels and csync_en=1 -> VGA_HS==~(HS^VS) delayed 3 ce_pix,
//     VGA_VS=1, colour/sync alignment matches a reference model.

Source files
------------

// File: rtl/video_mixer_pipe.sv
// video_mixer_pipe: three-stage registered video output mixer.
// Stage 1 masks blanking, widens colour to 8 bits and applies scanline dimming.
// Stage 2 forms the RGB->YPbPr products. Stage 3 scales, clamps and drives the pins.
// Sync and DE travel through the same three stages so they stay aligned with colour.
module video_mixer_pipe #(
    parameter int COLOR_W  = 6,
    parameter int OUT_W    = 6,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic [COLOR_W-1:0] R,
    input  logic [COLOR_W-1:0] G,
    input  logic [COLOR_W-1:0] B,
    input  logic               HSync,
    input  logic               VSync,
    input  logic               HBlank,
    input  logic               VBlank,
    input  logic [1:0]         scanlines,
    input  logic               ypbpr,
    input  logic               ypbpr_full,
    input  logic               csync_en,
    output logic [OUT_W-1:0]   VGA_R,
    output logic [OUT_W-1:0]   VGA_G,
    output logic [OUT_W-1:0]   VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_DE
);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    // Widen a component to 8 bits by repeating its bits from the MSB down.
    function automatic logic [7:0] expand8(input logic [COLOR_W-1:0] x);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = x[COLOR_W-1-(i % COLOR_W)];
        return e;
    endfunction

    // Scanline attenuation: 75%, 50% or 25% of the 8-bit value.
    function automatic logic [7:0] dim8(input logic [7:0] x, input logic [1:0] mode);
        case (mode)
            2'd1:    return (x >> 1) + (x >> 2);
            2'd2:    return x >> 1;
            2'd3:    return x >> 2;
            default: return x;
        endcase
    endfunction

    // Round a Q8 product to 8 bits, add the video offset and saturate to lo..hi.
    function automatic logic [7:0] scale_sat(input logic signed [17:0] p,
                                             input logic signed [19:0] off,
                                             input logic signed [19:0] hi);
        logic signed [19:0] t;
        t = (($signed({{2{p[17]}}, p}) + 20'sd128) >>> 8) + off;
        if (t < 20'sd16) t = 20'sd16;
        if (t > hi)      t = hi;
        return t[7:0];
    endfunction

    // Stretch limited-range luma 16..235 to 0..255.
    function automatic logic [7:0] full_y(input logic [7:0] y);
        logic [15:0] t;
        t = (({8'd0, y} - 16'd16) * 16'd150) >> 7;
        return (t > 16'd255) ? 8'd255 : t[7:0];
    endfunction

    // Stretch limited-range chroma 16..240 around 128 to 0..255.
    function automatic logic [7:0] full_c(input logic [7:0] c);
        logic signed [15:0] d;
        d = (($signed({8'd0, c}) - 16'sd128) * 16'sd146) >>> 7;
        d = d + 16'sd128;
        if (d < 16'sd0)   d = 16'sd0;
        if (d > 16'sd255) d = 16'sd255;
        return d[7:0];
    endfunction

    // Apply output sync polarity to a positive-going pulse.
    function automatic logic sync_pol(input logic x);
        return SYNC_POL ? x : ~x;
    endfunction

    // ---- stage 1: blank mask, widen, dim ----
    logic [7:0] r_p0, g_p0, b_p0;
    logic       hs_p0, vs_p0, vld_p0, line_flag;
    logic       de_in, dim_on;

    assign de_in  = ~(HBlank | VBlank);
    assign dim_on = line_flag && (scanlines != 2'd0);

    // Stage 1 registers plus odd-line flag driven by sync falling edges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p0 <= '0; g_p0 <= '0; b_p0 <= '0;
            hs_p0 <= 1'b0; vs_p0 <= 1'b0; vld_p0 <= 1'b0;
            line_flag <= 1'b0;
        end else if (ce_pix) begin
            r_p0   <= dim8(de_in ? expand8(R) : 8'd0, dim_on ? scanlines : 2'd0);
            g_p0   <= dim8(de_in ? expand8(G) : 8'd0, dim_on ? scanlines : 2'd0);
            b_p0   <= dim8(de_in ? expand8(B) : 8'd0, dim_on ? scanlines : 2'd0);
            hs_p0  <= HSync;
            vs_p0  <= VSync;
            vld_p0 <= de_in;
            if (vs_p0 && !VSync)      line_flag <= 1'b0;
            else if (hs_p0 && !HSync) line_flag <= ~line_flag;
        end
    end

    // ---- stage 2: colour-space products ----
    logic signed [17:0] rs, gs, bs, y_c, pb_c, pr_c;
    logic signed [17:0] y_p1, pb_p1, pr_p1;
    logic [7:0]         r_p1, g_p1, b_p1;
    logic               hs_p1, vs_p1, vld_p1, ypbpr_p1;

    assign rs   = $signed({10'd0, r_p0});
    assign gs   = $signed({10'd0, g_p0});
    assign bs   = $signed({10'd0, b_p0});
    assign y_c  = 18'sd66 * rs + 18'sd129 * gs + 18'sd25 * bs;
    assign pb_c = 18'sd112 * bs - 18'sd38 * rs - 18'sd74 * gs;
    assign pr_c = 18'sd112 * rs - 18'sd94 * gs - 18'sd18 * bs;

    // Stage 2 registers: RGB copy, products and the YPbPr mode bit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p1 <= '0; g_p1 <= '0; b_p1 <= '0;
            y_p1 <= '0; pb_p1 <= '0; pr_p1 <= '0;
            hs_p1 <= 1'b0; vs_p1 <= 1'b0; vld_p1 <= 1'b0; ypbpr_p1 <= 1'b0;
        end else if (ce_pix) begin
            r_p1 <= r_p0; g_p1 <= g_p0; b_p1 <= b_p0;
            y_p1 <= y_c; pb_p1 <= pb_c; pr_p1 <= pr_c;
            hs_p1 <= hs_p0; vs_p1 <= vs_p0; vld_p1 <= vld_p0;
            ypbpr_p1 <= ypbpr;
        end
    end

    // ---- stage 3: scale, clamp, select, drive pins ----
    logic [7:0] y_lim, pb_lim, pr_lim, y8, pb8, pr8, out_r8, out_g8, out_b8;

    assign y_lim  = scale_sat(y_p1,  20'sd16,  20'sd235);
    assign pb_lim = scale_sat(pb_p1, 20'sd128, 20'sd240);
    assign pr_lim = scale_sat(pr_p1, 20'sd128, 20'sd240);
    assign y8     = ypbpr_full ? full_y(y_lim)  : y_lim;
    assign pb8    = ypbpr_full ? full_c(pb_lim) : pb_lim;
    assign pr8    = ypbpr_full ? full_c(pr_lim) : pr_lim;
    assign out_r8 = ypbpr_p1 ? pr8 : r_p1;
    assign out_g8 = ypbpr_p1 ? y8  : g_p1;
    assign out_b8 = ypbpr_p1 ? pb8 : b_p1;

    // Output registers; composite sync replaces HS and parks VS high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
            VGA_HS <= SYNC_IDLE; VGA_VS <= SYNC_IDLE; VGA_DE <= 1'b0;
        end else if (ce_pix) begin
            VGA_R  <= out_r8[7 -: OUT_W];
            VGA_G  <= out_g8[7 -: OUT_W];
            VGA_B  <= out_b8[7 -: OUT_W];
            VGA_HS <= csync_en ? sync_pol(~(hs_p1 ^ vs_p1)) : sync_pol(hs_p1);
            VGA_VS <= csync_en ? 1'b1 : sync_pol(vs_p1);
            VGA_DE <= vld_p1;
        end
    end

endmodule

// File: tb/tb_video_mixer_pipe.sv
// tb_video_mixer_pipe: directed checks of video_mixer_pipe with 6-bit and 8-bit output copies.
module tb_video_mixer_pipe;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix  = 1'b1;
    logic [5:0] R = '0, G = '0, B = '0;
    logic       HSync = 0, VSync = 0, HBlank = 0, VBlank = 0;
    logic [1:0] scanlines = 2'd0;
    logic       ypbpr = 0, ypbpr_full = 0, csync_en = 0;

    logic [5:0] r6, g6, b6;
    logic [7:0] r8, g8, b8;
    logic       hs6, vs6, de6, hs8, vs8, de8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_sys = ~clk_sys;

    video_mixer_pipe #(.COLOR_W(6), .OUT_W(6), .SYNC_POL(1'b1)) dut6 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .scanlines(scanlines),
        .ypbpr(ypbpr), .ypbpr_full(ypbpr_full), .csync_en(csync_en),
        .VGA_R(r6), .VGA_G(g6), .VGA_B(b6),
        .VGA_HS(hs6), .VGA_VS(vs6), .VGA_DE(de6)
    );

    video_mixer_pipe #(.COLOR_W(6), .OUT_W(8), .SYNC_POL(1'b1)) dut8 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .scanlines(scanlines),
        .ypbpr(ypbpr), .ypbpr_full(ypbpr_full), .csync_en(csync_en),
        .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
        .VGA_HS(hs8), .VGA_VS(vs8), .VGA_DE(de8)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic set_px(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                          input logic hs, input logic vs, input logic hb, input logic vb);
        R = r; G = g; B = b; HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        ce_pix  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_px(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            step(1);
            nvec++;
            if ({r6, g6, b6} !== 18'd0 || r8 !== 8'd0 || de6 !== 1'b0 || hs6 !== 1'b0 || vs6 !== 1'b0) begin
                nerr++;
                $display("FAIL reset_hold[%0d]: rgb6=%h r8=%h de=%b hs=%b vs=%b, want all 0",
                         i, {r6, g6, b6}, r8, de6, hs6, vs6);
            end
        end
        set_px(6'h3F, 6'h20, 6'h00, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(2);
        nvec++;
        if (de6 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_latency_early: de=%b, want 0 after 2 ce", de6);
        end
        step(1);
        nvec++;
        if (de6 !== 1'b1 || r6 !== 6'd63) begin
            nerr++;
            $display("FAIL reset_latency: de=%b r=%0d, want de=1 r=63 after 3 ce", de6, r6);
        end
    endtask

    task automatic test_rgb_pass;
        set_px(6'h3F, 6'h20, 6'h00, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (r6 !== 6'd63 || g6 !== 6'd32 || b6 !== 6'd0 || de6 !== 1'b1) begin
            nerr++;
            $display("FAIL rgb6: r=%0d g=%0d b=%0d de=%b, want 63 32 0 1", r6, g6, b6, de6);
        end
        nvec++;
        if (r8 !== 8'd255 || g8 !== 8'd130 || b8 !== 8'd0) begin
            nerr++;
            $display("FAIL rgb8_expand: r=%0d g=%0d b=%0d, want 255 130 0", r8, g8, b8);
        end
        set_px(6'h3F, 6'h20, 6'h00, 0, 0, 1, 0);
        step(3);
        nvec++;
        if ({r6, g6, b6} !== 18'd0 || de6 !== 1'b0) begin
            nerr++;
            $display("FAIL hblank: rgb=%h de=%b, want 0 0", {r6, g6, b6}, de6);
        end
        set_px(6'h15, 6'h2A, 6'h3F, 0, 0, 0, 1);
        step(3);
        nvec++;
        if ({r6, g6, b6} !== 18'd0 || de6 !== 1'b0) begin
            nerr++;
            $display("FAIL vblank: rgb=%h de=%b, want 0 0", {r6, g6, b6}, de6);
        end
    endtask

    task automatic test_ce_hold;
        set_px(6'h12, 6'h34, 6'h05, 0, 0, 0, 0);
        step(3);
        ce_pix = 1'b0;
        set_px(6'h3F, 6'h3F, 6'h3F, 1, 1, 0, 0);
        step(6);
        nvec++;
        if (r6 !== 6'h12 || g6 !== 6'h34 || b6 !== 6'h05 || hs6 !== 1'b0) begin
            nerr++;
            $display("FAIL ce_hold: r=%h g=%h b=%h hs=%b, want 12 34 05 0", r6, g6, b6, hs6);
        end
        set_px(6'h3F, 6'h3F, 6'h3F, 0, 0, 0, 0);
        ce_pix = 1'b1;
        step(3);
        nvec++;
        if (r6 !== 6'h3F || b6 !== 6'h3F) begin
            nerr++;
            $display("FAIL ce_resume: r=%h b=%h, want 3f 3f", r6, b6);
        end
    endtask

    task automatic test_scanlines;
        scanlines = 2'd2;
        set_px(6'h3F, 6'h3F, 6'h3F, 0, 0, 0, 0);
        step(4);
        nvec++;
        if (r6 !== 6'd63) begin
            nerr++;
            $display("FAIL scan_line1: r=%0d, want 63", r6);
        end
        HSync = 1; step(1); HSync = 0; step(4);
        nvec++;
        if (r6 !== 6'd31 || g8 !== 8'd127) begin
            nerr++;
            $display("FAIL scan_line2_50: r6=%0d g8=%0d, want 31 127", r6, g8);
        end
        scanlines = 2'd1; step(4);
        nvec++;
        if (r6 !== 6'd47 || g8 !== 8'd190) begin
            nerr++;
            $display("FAIL scan_75: r6=%0d g8=%0d, want 47 190", r6, g8);
        end
        scanlines = 2'd3; step(4);
        nvec++;
        if (r6 !== 6'd15 || g8 !== 8'd63) begin
            nerr++;
            $display("FAIL scan_25: r6=%0d g8=%0d, want 15 63", r6, g8);
        end
        scanlines = 2'd2;
        VSync = 1; step(1); VSync = 0; step(4);
        nvec++;
        if (r6 !== 6'd63) begin
            nerr++;
            $display("FAIL scan_vsync_clear: r=%0d, want 63", r6);
        end
        HSync = 1; VSync = 1; step(1); HSync = 0; VSync = 0; step(4);
        nvec++;
        if (r6 !== 6'd63) begin
            nerr++;
            $display("FAIL scan_hv_same_fall: r=%0d, want 63", r6);
        end
        HSync = 1; step(1); HSync = 0; step(4);
        nvec++;
        if (r6 !== 6'd31) begin
            nerr++;
            $display("FAIL scan_toggle_again: r=%0d, want 31", r6);
        end
        scanlines = 2'd0;
        VSync = 1; step(1); VSync = 0; step(4);
    endtask

    task automatic test_ypbpr_limited;
        ypbpr = 1; ypbpr_full = 0;
        set_px(6'h3F, 6'h3F, 6'h3F, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (g8 !== 8'd235 || b8 !== 8'd128 || r8 !== 8'd128 || g6 !== 6'd58) begin
            nerr++;
            $display("FAIL ypbpr_lim_white: Y=%0d Pb=%0d Pr=%0d Y6=%0d, want 235 128 128 58", g8, b8, r8, g6);
        end
        set_px(6'h00, 6'h00, 6'h00, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (g8 !== 8'd16 || b8 !== 8'd128 || r8 !== 8'd128) begin
            nerr++;
            $display("FAIL ypbpr_lim_black: Y=%0d Pb=%0d Pr=%0d, want 16 128 128", g8, b8, r8);
        end
        set_px(6'h00, 6'h00, 6'h3F, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (g8 !== 8'd41 || b8 !== 8'd240 || r8 !== 8'd110) begin
            nerr++;
            $display("FAIL ypbpr_lim_blue: Y=%0d Pb=%0d Pr=%0d, want 41 240 110", g8, b8, r8);
        end
    endtask

    task automatic test_ypbpr_full;
        ypbpr = 1; ypbpr_full = 1;
        set_px(6'h3F, 6'h3F, 6'h3F, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (g8 !== 8'd255 || b8 !== 8'd128 || r8 !== 8'd128) begin
            nerr++;
            $display("FAIL ypbpr_full_white: Y=%0d Pb=%0d Pr=%0d, want 255 128 128", g8, b8, r8);
        end
        set_px(6'h00, 6'h00, 6'h00, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (g8 !== 8'd0 || b8 !== 8'd128) begin
            nerr++;
            $display("FAIL ypbpr_full_black: Y=%0d Pb=%0d, want 0 128", g8, b8);
        end
        set_px(6'h00, 6'h00, 6'h3F, 0, 0, 0, 0);
        step(3);
        nvec++;
        if (b8 !== 8'd255 || g8 !== 8'd29 || r8 !== 8'd107) begin
            nerr++;
            $display("FAIL ypbpr_full_blue: Y=%0d Pb=%0d Pr=%0d, want 29 255 107", g8, b8, r8);
        end
        ypbpr = 0; ypbpr_full = 0;
    endtask

    task automatic test_sync_polarity;
        csync_en = 0;
        set_px(6'h01, 6'h02, 6'h03, 1, 0, 0, 0);
        step(3);
        nvec++;
        if (hs6 !== 1'b1 || vs6 !== 1'b0) begin
            nerr++;
            $display("FAIL sync_hs: hs=%b vs=%b, want 1 0", hs6, vs6);
        end
        set_px(6'h01, 6'h02, 6'h03, 0, 1, 0, 0);
        step(3);
        nvec++;
        if (hs6 !== 1'b0 || vs6 !== 1'b1) begin
            nerr++;
            $display("FAIL sync_vs: hs=%b vs=%b, want 0 1", hs6, vs6);
        end
        set_px(6'h01, 6'h02, 6'h03, 0, 0, 0, 0);
        step(3);
    endtask

    task automatic test_csync_ce4;
        logic [5:0] er[0:39];
        logic [5:0] eg[0:39];
        logic       ehs[0:39];
        logic       ede[0:39];
        logic [5:0] rr, gg;
        logic       hh, vv, hb, vb;
        csync_en = 1;
        scanlines = 2'd0;
        ypbpr = 0;
        for (int k = 0; k < 40; k++) begin
            rr = 6'($urandom); gg = 6'($urandom);
            hh = ($urandom_range(0, 3) == 0); vv = ($urandom_range(0, 4) == 0);
            hb = ($urandom_range(0, 3) == 0); vb = ($urandom_range(0, 5) == 0);
            set_px(rr, gg, 6'($urandom), hh, vv, hb, vb);
            ede[k] = ~(hb | vb);
            er[k]  = ede[k] ? rr : 6'd0;
            eg[k]  = ede[k] ? gg : 6'd0;
            ehs[k] = ~(hh ^ vv);
            ce_pix = 1'b1;
            step(1);
            ce_pix = 1'b0;
            if (k >= 2) begin
                nvec++;
                if (r6 !== er[k-2] || g6 !== eg[k-2] || de6 !== ede[k-2] ||
                    hs6 !== ehs[k-2] || vs6 !== 1'b1) begin
                    nerr++;
                    $display("FAIL csync_ce4[%0d]: r=%h g=%h de=%b hs=%b vs=%b, want %h %h %b %b 1",
                             k, r6, g6, de6, hs6, vs6, er[k-2], eg[k-2], ede[k-2], ehs[k-2]);
                end
            end
            step(3);
        end
        ce_pix = 1'b1;
        csync_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_sys);
        test_reset;
        test_rgb_pass;
        test_ce_hold;
        test_scanlines;
        test_ypbpr_limited;
        test_ypbpr_full;
        test_sync_polarity;
        test_csync_ce4;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
